operand_fetch: RTL
==================

Name: operand_fetch

Overview:
Operand-fetch stage directly upstream of the 16-bit ALU.
- Holds the architectural register file and the carry/zero flag register.
- Reads two source registers and optionally substitutes an immediate for operand B.
- Registers A, B, ALU_Code and the destination address into a one-entry valid/ready pipeline slot that drives the ALU inputs.
- Accepts writeback of the ALU result and flags, with same-cycle bypass to the read path.

Parameters:
DATA_W, 16, operand/register width
NUM_REGS, 8, number of architectural registers; R0 is hardwired to zero
ADDR_W, 3, register address width; must equal clog2(NUM_REGS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoder presents an instruction
in_ready  out  1  stage can accept this cycle
rs1_addr  in  ADDR_W  source register for A
rs2_addr  in  ADDR_W  source register for B
use_imm  in  1  1: B = imm instead of rs2
imm  in  DATA_W  immediate operand
alu_code_in  in  3  ALU operation code, passed through unchanged
rd_addr_in  in  ADDR_W  destination register, passed through
out_valid  out  1  A/B/ALU_Code/rd_addr_out are valid
out_ready  in  1  execute stage consumes this cycle
A  out  DATA_W  operand A to ALU
B  out  DATA_W  operand B to ALU
ALU_Code  out  3  operation code to ALU
rd_addr_out  out  ADDR_W  destination carried to writeback
wb_en  in  1  write wb_data to wb_addr
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback value, typically ALU_Out
wb_flag_en  in  1  update the flag register
wb_carry  in  1  ALU Carry
wb_zero  in  1  ALU isZero
flag_carry  out  1  registered carry flag
flag_zero  out  1  registered zero flag

Behaviour:
- Reset (async, rst_n=0): all registers R0..R7 = 0; flag_carry = 0; flag_zero = 0; out_valid = 0; A = 0; B = 0; ALU_Code = 0; rd_addr_out = 0.
  - Reset takes effect immediately, without waiting for a clock edge, including while a transfer is pending.
  - A held slot is discarded.
- Register write: at posedge when wb_en=1 and wb_addr != 0. Writes to R0 are ignored.
- Register read: combinational.
  - Address 0 returns 0.
  - Bypass: if wb_en=1, wb_addr == rsN_addr and rsN_addr != 0, the read returns wb_data (write-before-read in the same cycle).
- Operand mux: B_next = use_imm ? imm : read(rs2_addr). A_next = read(rs1_addr).
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept occurs when in_valid && in_ready.
  - On accept at posedge: A, B, ALU_Code, rd_addr_out are loaded from the current-cycle reads/inputs, and out_valid = 1.
  - Else if out_ready: out_valid = 0.
- Slot stability: while out_valid=1 and out_ready=0, outputs hold stable and in_ready = 0.
- Latency and throughput: 1 cycle from accept to out_valid. Throughput is 1 per cycle when out_ready is held at 1.
- Captured operands are not refreshed: a writeback to a source register after capture does not change the held A/B.
- Flags: at posedge when wb_flag_en=1, flag_carry <= wb_carry and flag_zero <= wb_zero. Independent of wb_en.
- Width: all data paths are DATA_W wide, with no extension or truncation. Codes 000..111 pass through unchanged.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W, NUM_REGS, ALU op code constants (ADD=000, SUB=001, SHR=010, SLT=011, AND=100, OR=101, NOT=110, XOR=111).
- One natural sub-module, regfile_2r1w: register array, R0 rule, two async read ports with bypass, one write port.
- The pipeline slot and flag register stay in operand_fetch.

Test Plan:
1. Reset: rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, A=B=0, flags=0 immediately; every register reads 0 afterwards.
2. Write/read: write R3=0x1234, R5=0x00FF; then accept rs1=3, rs2=5, alu_code_in=100, rd=2 -> next cycle out_valid=1, A=0x1234, B=0x00FF, ALU_Code=100, rd_addr_out=2.
3. Bypass: wb_en=1, wb_addr=4, wb_data=0xBEEF in the same cycle as accepting rs1=4 -> A=0xBEEF; R4 reads 0xBEEF thereafter.
4. R0 rule: wb_en=1, wb_addr=0, wb_data=0xFFFF; then rs1=0, use_imm=1, imm=0x0007 -> A=0x0000, B=0x0007.
5. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. When out_ready=1, next instruction accepted that cycle and presented the following cycle; no loss or duplication.
6. Flags: wb_flag_en=1, wb_carry=1, wb_zero=0 -> flag_carry=1, flag_zero=0; then wb_flag_en=0 with wb_zero=1 -> flags unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, ALU op codes and types for the CPU front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 8;
    localparam int ADDR_W     = $clog2(NUM_REGS);
    localparam int ALU_CODE_W = 3;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SHR = 3'b010,
        ALU_SLT = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_NOT = 3'b110,
        ALU_XOR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports with write bypass, one write port, R0 reads zero.
// Latency: reads 0 cycles (bypass returns same-cycle write data); writes land at posedge.
// Backpressure: none, every write and read is accepted unconditionally.
//
// Ports: clk/rst_n; wr_en/wr_addr/wr_data write port; rd0_*/rd1_* read ports.
module regfile_2r1w #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // R0 is never written, so its storage always stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Write-before-read: a same-cycle write to the addressed register wins.
    always_comb begin
        rd0_data = '0;
        if (rd0_addr != '0) begin
            rd0_data = (wr_en && (wr_addr == rd0_addr)) ? wr_data : regs[rd0_addr];
        end
    end

    always_comb begin
        rd1_data = '0;
        if (rd1_addr != '0) begin
            rd1_data = (wr_en && (wr_addr == rd1_addr)) ? wr_data : regs[rd1_addr];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads rs1/rs2 (or immediate), registers A/B/op/rd into a one-entry slot feeding the ALU.
// Latency: 1 cycle from accept to out_valid; 1 instruction per cycle while out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a held slot is frozen until consumed.
//
// Ports: decoder side in_valid/in_ready/rs1_addr/rs2_addr/use_imm/imm/alu_code_in/rd_addr_in;
//        ALU side out_valid/out_ready/A/B/ALU_Code/rd_addr_out;
//        writeback wb_en/wb_addr/wb_data and wb_flag_en/wb_carry/wb_zero -> flag_carry/flag_zero.
module operand_fetch #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ADDR_W   = cpu_pkg::ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_W-1:0]              rs1_addr,
    input  logic [ADDR_W-1:0]              rs2_addr,
    input  logic                           use_imm,
    input  logic [DATA_W-1:0]              imm,
    input  logic [cpu_pkg::ALU_CODE_W-1:0] alu_code_in,
    input  logic [ADDR_W-1:0]              rd_addr_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              A,
    output logic [DATA_W-1:0]              B,
    output logic [cpu_pkg::ALU_CODE_W-1:0] ALU_Code,
    output logic [ADDR_W-1:0]              rd_addr_out,
    input  logic                           wb_en,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           wb_flag_en,
    input  logic                           wb_carry,
    input  logic                           wb_zero,
    output logic                           flag_carry,
    output logic                           flag_zero
);

    import cpu_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
        logic [ALU_CODE_W-1:0] code;
        logic [ADDR_W-1:0]     rd;
    } slot_t;

    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              accept;
    slot_t             slot_d;
    slot_t             slot_q;
    logic              slot_vld;

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd0_addr (rs1_addr),
        .rd0_data (rs1_data),
        .rd1_addr (rs2_addr),
        .rd1_data (rs2_data)
    );

    assign in_ready = !slot_vld || out_ready;
    assign accept   = in_valid && in_ready;

    assign slot_d.a    = rs1_data;
    assign slot_d.b    = use_imm ? imm : rs2_data;
    assign slot_d.code = alu_code_in;
    assign slot_d.rd   = rd_addr_in;

    // Payload only loads on accept, so a stalled slot and captured operands never change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            slot_vld <= 1'b0;
        end else if (accept) begin
            slot_q   <= slot_d;
            slot_vld <= 1'b1;
        end else if (out_ready) begin
            slot_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
        end else if (wb_flag_en) begin
            flag_carry <= wb_carry;
            flag_zero  <= wb_zero;
        end
    end

    assign out_valid   = slot_vld;
    assign A           = slot_q.a;
    assign B           = slot_q.b;
    assign ALU_Code    = slot_q.code;
    assign rd_addr_out = slot_q.rd;

endmodule
